// File: rtl/alu_reg_sequencer_pkg.sv
// Shared definitions for the ALU/register command sequencer: opcodes,
// FSM state encoding and width defaults.
package alu_reg_sequencer_pkg;

  localparam int unsigned W_DEFAULT     = 4;
  localparam int unsigned CNT_W_DEFAULT = 8;

  // Bit 3 clear selects an ALU operation whose function code is op[2:0]
  localparam int unsigned ALU_CLASS_BIT = 3;

  localparam logic [3:0] OP_CLR  = 4'b1000;
  localparam logic [3:0] OP_LOAD = 4'b1001;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_READ = 4'b1110;
  localparam logic [3:0] OP_RSV  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } seq_state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return ~op[ALU_CLASS_BIT];
  endfunction

endpackage

// File: rtl/alu_reg_sequencer_decode.sv
// Combinational decode of a latched command into ALU and register controls;
// everything is held at zero unless exec_en is high.
module seq_decode
  import alu_reg_sequencer_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         exec_en,
  input  logic [3:0]   op,
  input  logic [W-1:0] data,
  input  logic [W-1:0] reg_out,
  input  logic [W-1:0] alu_f,
  output logic [2:0]   alu_oc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         reg_cl,
  output logic         reg_ld,
  output logic         reg_inc,
  output logic         reg_dec,
  output logic         reg_sr,
  output logic         reg_ir,
  output logic         reg_sl,
  output logic         reg_il,
  output logic [W-1:0] reg_in
);

  always_comb begin
    alu_oc  = '0;
    alu_a   = '0;
    alu_b   = '0;
    reg_cl  = 1'b0;
    reg_ld  = 1'b0;
    reg_inc = 1'b0;
    reg_dec = 1'b0;
    reg_sr  = 1'b0;
    reg_ir  = 1'b0;
    reg_sl  = 1'b0;
    reg_il  = 1'b0;
    reg_in  = '0;
    if (exec_en) begin
      if (is_alu_op(op)) begin
        // Result of the ALU is written straight back into the register
        alu_oc = op[2:0];
        alu_a  = reg_out;
        alu_b  = data;
        reg_ld = 1'b1;
        reg_in = alu_f;
      end else begin
        case (op)
          OP_CLR:  reg_cl  = 1'b1;
          OP_LOAD: begin
            reg_ld = 1'b1;
            reg_in = data;
          end
          OP_INC:  reg_inc = 1'b1;
          OP_DEC:  reg_dec = 1'b1;
          OP_SHR:  begin
            reg_sr = 1'b1;
            reg_ir = data[0];
          end
          OP_SHL:  begin
            reg_sl = 1'b1;
            reg_il = data[0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_reg_sequencer.sv
// Command sequencer driving a 4-bit ALU and register: accept a command,
// execute it for one cycle, then return the register value as a response.
module alu_reg_sequencer
  import alu_reg_sequencer_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [W-1:0]     cmd_data,
  output logic [2:0]       alu_oc,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_f,
  output logic             reg_cl,
  output logic             reg_ld,
  output logic             reg_inc,
  output logic             reg_dec,
  output logic             reg_sr,
  output logic             reg_ir,
  output logic             reg_sl,
  output logic             reg_il,
  output logic [W-1:0]     reg_in,
  input  logic [W-1:0]     reg_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_err,
  output logic [CNT_W-1:0] exec_cnt
);

  seq_state_t   state, state_nxt;
  logic [3:0]   op_q;
  logic [W-1:0] data_q;
  logic         cmd_fire;
  logic         res_fire;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign res_fire = res_valid & res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    res_err   = 1'b0;
    case (state)
      S_IDLE: begin
        // Held low during reset even though the state already reads IDLE
        cmd_ready = ~rst;
        if (cmd_valid && !rst) state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        res_valid = 1'b1;
        res_data  = reg_out;
        res_err   = (op_q == OP_RSV);
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      data_q <= '0;
    end else if (cmd_fire) begin
      op_q   <= cmd_op;
      data_q <= cmd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           exec_cnt <= '0;
    else if (res_fire) exec_cnt <= exec_cnt + 1'b1;
  end

  seq_decode #(.W(W)) u_decode (
    .exec_en (state == S_EXEC),
    .op      (op_q),
    .data    (data_q),
    .reg_out (reg_out),
    .alu_f   (alu_f),
    .alu_oc  (alu_oc),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .reg_cl  (reg_cl),
    .reg_ld  (reg_ld),
    .reg_inc (reg_inc),
    .reg_dec (reg_dec),
    .reg_sr  (reg_sr),
    .reg_ir  (reg_ir),
    .reg_sl  (reg_sl),
    .reg_il  (reg_il),
    .reg_in  (reg_in)
  );

endmodule
